// File: rtl/rotation_pkg.sv
// rotation_pkg: ASCII constants, parser states and default distance width for rotation_parser.
package rotation_pkg;
  localparam int DIST_W_DEF = 32;
  localparam logic [7:0] CH_L   = 8'h4C;
  localparam logic [7:0] CH_R   = 8'h52;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_NUL = 8'h00;
  typedef enum logic [1:0] {
    S_DIR   = 2'd0,
    S_DIGIT = 2'd1,
    S_SKIP  = 2'd2
  } state_t;
endpackage

// File: rtl/decimal_acc.sv
// decimal_acc: acc*10 + digit, saturating to all-ones with an overflow flag.
module decimal_acc #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] nxt,
  output logic         ovf
);
  logic [W+3:0] prod;
  always_comb begin
    prod = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{W{1'b0}}, digit};
    ovf  = |prod[W+3:W];
    nxt  = ovf ? '1 : prod[W-1:0];
  end
endmodule

// File: rtl/rotation_parser.sv
// rotation_parser: turns an ASCII stream of "L<n>"/"R<n>" lines into rotation handshakes.
module rotation_parser
  import rotation_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic [DIST_W-1:0] data_in,
  output logic              dir_r,
  output logic              rot_valid,
  input  logic              rot_ready,
  output logic [15:0]       rot_count,
  output logic [15:0]       err_count,
  output logic              overflow
);
  state_t            state_q, state_d;
  logic [DIST_W-1:0] acc_q, acc_d, data_q, data_d, acc_nxt;
  logic              seen_q, seen_d, line_dir_q, line_dir_d, dir_q, dir_d;
  logic              rot_valid_q, rot_valid_d, ovf_q, ovf_d, acc_ovf;
  logic [15:0]       rot_count_q, rot_count_d, err_count_q, err_count_d;
  logic              accept, emit, err_inc;
  logic              is_digit, is_term, is_dir, is_ws, is_blank;
  decimal_acc #(.W(DIST_W)) u_acc (
    .acc  (acc_q),
    .digit(char_in[3:0]),
    .nxt  (acc_nxt),
    .ovf  (acc_ovf)
  );
  assign char_ready = !rot_valid_q || rot_ready;
  assign accept     = char_valid && char_ready;
  assign is_digit   = char_in >= CH_0 && char_in <= CH_9;
  assign is_term    = char_in == CH_LF || char_in == CH_NUL;
  assign is_dir     = char_in == CH_L || char_in == CH_R;
  assign is_ws      = char_in == CH_CR || char_in == CH_SP;
  assign is_blank   = is_term || is_ws;
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    seen_d     = seen_q;
    line_dir_d = line_dir_q;
    ovf_d      = ovf_q;
    emit       = 1'b0;
    err_inc    = 1'b0;
    if (accept) begin
      case (state_q)
        S_DIR: begin
          if (is_dir) begin
            line_dir_d = char_in == CH_R;
            acc_d      = '0;
            seen_d     = 1'b0;
            state_d    = S_DIGIT;
          end else if (!is_blank) begin
            err_inc = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_DIGIT: begin
          if (is_digit) begin
            acc_d  = acc_nxt;
            seen_d = 1'b1;
            ovf_d  = ovf_q | acc_ovf;
          end else if (is_term) begin
            emit    = seen_q;
            err_inc = !seen_q;
            state_d = S_DIR;
          end else if (!is_ws) begin
            err_inc = 1'b1;
            state_d = S_SKIP;
          end
        end
        default: state_d = is_term ? S_DIR : state_q;
      endcase
    end
    // a new load wins over a same-cycle handshake so no rotation is lost
    rot_valid_d = emit || (rot_valid_q && !rot_ready);
    data_d      = emit ? acc_q : data_q;
    dir_d       = emit ? line_dir_q : dir_q;
    rot_count_d = (emit && rot_count_q != 16'hFFFF) ? rot_count_q + 16'd1 : rot_count_q;
    err_count_d = (err_inc && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_DIR;
      acc_q       <= '0;
      seen_q      <= 1'b0;
      line_dir_q  <= 1'b0;
      data_q      <= '0;
      dir_q       <= 1'b0;
      rot_valid_q <= 1'b0;
      rot_count_q <= '0;
      err_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      seen_q      <= seen_d;
      line_dir_q  <= line_dir_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
      rot_valid_q <= rot_valid_d;
      rot_count_q <= rot_count_d;
      err_count_q <= err_count_d;
      ovf_q       <= ovf_d;
    end
  end
  assign data_in   = data_q;
  assign dir_r     = dir_q;
  assign rot_valid = rot_valid_q;
  assign rot_count = rot_count_q;
  assign err_count = err_count_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_rotation_parser.sv
// tb_rotation_parser: scoreboard bench with a line-level reference model of the rotation grammar.
module tb_rotation_parser;
  import rotation_pkg::*;
  localparam int W = 32;
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    char_in = 8'h00;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic [W-1:0]  data_in;
  logic          dir_r;
  logic          rot_valid;
  logic          rot_ready = 1'b1;
  logic [15:0]   rot_count;
  logic [15:0]   err_count;
  logic          overflow;
  rotation_parser #(.DIST_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .data_in   (data_in),
    .dir_r     (dir_r),
    .rot_valid (rot_valid),
    .rot_ready (rot_ready),
    .rot_count (rot_count),
    .err_count (err_count),
    .overflow  (overflow)
  );
  always #5 clk = ~clk;
  int           n_chk = 0;
  int           n_pass = 0;
  bit [32:0]    exp_q[$];
  byte unsigned lbuf[$];
  int           exp_rot = 0;
  int           exp_err = 0;
  bit           exp_ovf = 0;
  int           ready_mode = 0;
  bit           feed_done = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask
  // Reference model: judge a whole line once its terminator is seen
  function automatic void end_line();
    int i = 0;
    bit d, any = 0, bad = 0, o = 0;
    longint unsigned v = 0;
    while (i < lbuf.size() && (lbuf[i] == CH_CR || lbuf[i] == CH_SP)) i++;
    if (i == lbuf.size()) return;
    if (lbuf[i] != CH_L && lbuf[i] != CH_R) begin
      exp_err++;
      return;
    end
    d = lbuf[i] == CH_R;
    for (int j = i + 1; j < lbuf.size(); j++) begin
      if (lbuf[j] == CH_CR || lbuf[j] == CH_SP) continue;
      if (lbuf[j] >= CH_0 && lbuf[j] <= CH_9) begin
        any = 1;
        v = v * 10 + longint'(lbuf[j] - CH_0);
        if (v > MAXV) begin
          v = MAXV;
          o = 1;
        end
      end else begin
        bad = 1;
        break;
      end
    end
    if (o) exp_ovf = 1;
    if (bad || !any) exp_err++;
    else begin
      exp_q.push_back({d, v[31:0]});
      exp_rot++;
    end
  endfunction
  function automatic void model_byte(input byte unsigned b);
    if (b == CH_LF || b == CH_NUL) begin
      end_line();
      lbuf.delete();
    end else lbuf.push_back(b);
  endfunction
  task automatic send_byte(input byte unsigned b);
    int guard = 0;
    char_in    = b;
    char_valid = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!char_ready && guard < 1000);
    if (!char_ready) begin
      chk("accept_timeout", 0, 1);
      char_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    model_byte(b);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask
  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);
  endtask
  task automatic check_counts();
    @(negedge clk);
    chk("rot_count", rot_count, 16'(exp_rot));
    chk("err_count", err_count, 16'(exp_err));
    chk("overflow", overflow, exp_ovf);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst        = 1'b1;
    char_valid = 1'b0;
    lbuf.delete();
    exp_q.delete();
    exp_rot = 0;
    exp_err = 0;
    exp_ovf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rot_valid", rot_valid, 0);
    chk("rst_data", data_in, 0);
    chk("rst_dir", dir_r, 0);
    chk("rst_counts", {rot_count, err_count}, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_char_ready", char_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic rand_line();
    int k = $urandom_range(0, 9);
    int n;
    if (k < 6) begin
      send_byte($urandom_range(0, 1) ? CH_R : CH_L);
      n = (k == 0) ? $urandom_range(9, 12) : $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) send_byte($urandom_range(0, 1) ? CH_SP : CH_CR);
        send_byte(8'(CH_0 + $urandom_range(0, 9)));
      end
    end else if (k < 9) begin
      n = $urandom_range(0, 4);
      if (k == 8) send_byte($urandom_range(0, 1) ? CH_R : CH_L);
      for (int i = 0; i < n; i++) send_byte(8'($urandom_range(32, 126)));
    end else if ($urandom_range(0, 1)) send_byte(CH_SP);
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
    send_byte($urandom_range(0, 4) == 0 ? CH_NUL : CH_LF);
  endtask
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) rot_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 0) rot_ready = 1'b1;
  end
  logic [W-1:0] prev_data;
  logic         prev_dir;
  bit           prev_stall = 0;
  bit [32:0]    e;
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_data_stable", data_in, prev_data);
        chk("stall_dir_stable", dir_r, prev_dir);
      end
      if (rot_valid && rot_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rotation", {dir_r, data_in}, 0);
        else begin
          e = exp_q.pop_front();
          chk("rot_data", data_in, e[31:0]);
          chk("rot_dir", dir_r, e[32]);
        end
      end
      prev_stall = rot_valid && !rot_ready;
      prev_data  = data_in;
      prev_dir   = dir_r;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int g;
    do_reset();
    ready_mode = 0;
    send_str("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n");
    drain();
    check_counts();
    chk("aoc_rot_count", rot_count, 10);
    do_reset();
    send_str("R12\r\n\nX9\nL\nR3");
    send_byte(CH_NUL);
    drain();
    check_counts();
    chk("mixed_err_count", err_count, 2);
    do_reset();
    ready_mode = 2;
    rot_ready  = 1'b0;
    feed_done  = 0;
    fork
      begin
        send_str("L68\nR2\n");
        feed_done = 1;
      end
    join_none
    g = 0;
    while (!rot_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (5) begin
      @(negedge clk);
      chk("blocked_char_ready", char_ready, 0);
      chk("blocked_data", data_in, 68);
    end
    @(posedge clk);
    #1;
    rot_ready  = 1'b1;
    ready_mode = 0;
    g = 0;
    while (!feed_done && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("blocked_feed_done", feed_done, 1);
    drain();
    check_counts();
    do_reset();
    send_str("R99999999999\n");
    drain();
    check_counts();
    chk("sat_overflow", overflow, 1);
    chk("sat_data", data_in, 32'hFFFF_FFFF);
    do_reset();
    send_str("R4");
    do_reset();
    send_str("L7\n");
    drain();
    check_counts();
    chk("reset_mid_rot_count", rot_count, 1);
    do_reset();
    send_str("L1\nR2\nR007\nL0\n\n L3 \r\n");
    drain();
    check_counts();
    do_reset();
    ready_mode = 1;
    for (int i = 0; i < 200; i++) rand_line();
    drain();
    ready_mode = 0;
    check_counts();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
